// File: rtl/cpu_clock_control_if.sv
// cpu_clock_control_if: raw button levels in, CPU clock/reset/status out
interface cpu_clock_control_if;
    logic       auto_en_raw;
    logic       step_raw;
    logic       reset_req_raw;
    logic       cpu_clk_en;
    logic       cpu_reset;
    logic       run_mode;
    logic [1:0] ctrl_state;
    logic [7:0] tick_count;

    modport master (
        output auto_en_raw, step_raw, reset_req_raw,
        input  cpu_clk_en, cpu_reset, run_mode, ctrl_state, tick_count
    );

    modport slave (
        input  auto_en_raw, step_raw, reset_req_raw,
        output cpu_clk_en, cpu_reset, run_mode, ctrl_state, tick_count
    );
endinterface

// File: rtl/cpu_clock_control.sv
// cpu_clock_control: debounced HOLD/MANUAL/AUTO clock-enable and reset stretcher for the CPU
module cpu_clock_control #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int AUTO_DIV        = 25000000,
    parameter int RESET_HOLD      = 4
) (
    input logic              clk,
    input logic              reset_n,
    cpu_clock_control_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AW = $clog2(AUTO_DIV);
    localparam int HW = $clog2(RESET_HOLD + 1);

    typedef enum logic [1:0] {HOLD = 2'd0, MANUAL = 2'd1, AUTO = 2'd2} state_t;

    logic [2:0] raw, sync1_q, sync2_q, deb;
    state_t     state_q, state_d;
    logic [AW-1:0] div_q, div_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0] tick_q, tick_d;
    logic       rise_q, step_prev_q, cpu_reset_q, run_mode_q, clk_en;

    assign raw = {bus.reset_req_raw, bus.step_raw, bus.auto_en_raw};

    // two-flop synchronisers for the three button levels
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_deb
        logic [DW-1:0] cnt_q;
        logic          deb_q;
        // accept a new level only after it has differed for DEBOUNCE_CYCLES in a row
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
                deb_q <= 1'b0;
            end else if (sync2_q[g] == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q + 1'b1 == DW'(DEBOUNCE_CYCLES)) begin
                cnt_q <= '0;
                deb_q <= sync2_q[g];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
        assign deb[g] = deb_q;
    end

    // next state: reset request beats a mode change, which beats a tick
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        hold_d  = hold_q;
        clk_en  = 1'b0;
        if (deb[2]) begin
            state_d = HOLD;
            div_d   = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                HOLD: begin
                    div_d  = '0;
                    hold_d = hold_q + 1'b1;
                    if (hold_q + 1'b1 == HW'(RESET_HOLD))
                        state_d = deb[0] ? AUTO : MANUAL;
                end
                MANUAL: begin
                    if (deb[0]) begin
                        state_d = AUTO;
                        div_d   = '0;
                    end else begin
                        clk_en = rise_q;
                    end
                end
                AUTO: begin
                    if (!deb[0]) begin
                        state_d = MANUAL;
                        div_d   = '0;
                    end else if (div_q == AW'(AUTO_DIV - 1)) begin
                        clk_en = 1'b1;
                        div_d  = '0;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                default: state_d = HOLD;
            endcase
        end
        tick_d = (state_d == HOLD) ? 8'd0 : tick_q + 8'(clk_en);
    end

    // state, counters, step edge detector and registered status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= HOLD;
            div_q       <= '0;
            hold_q      <= '0;
            tick_q      <= '0;
            rise_q      <= 1'b0;
            step_prev_q <= 1'b0;
            cpu_reset_q <= 1'b1;
            run_mode_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            hold_q      <= hold_d;
            tick_q      <= tick_d;
            rise_q      <= deb[1] & ~step_prev_q;
            step_prev_q <= deb[1];
            cpu_reset_q <= (state_d == HOLD);
            run_mode_q  <= (state_d == AUTO);
        end
    end

    assign bus.cpu_clk_en = clk_en;
    assign bus.cpu_reset  = cpu_reset_q;
    assign bus.run_mode   = run_mode_q;
    assign bus.ctrl_state = state_q;
    assign bus.tick_count = tick_q;
endmodule

// File: doc/cpu_clock_control.md
Name: cpu_clock_control

Overview:
Sits directly downstream of the board I/O mapping. It consumes the raw clk_auto_en, clk_step and reset button levels and produces the CPU's clock-enable pulse and a stretched CPU reset. The block synchronises and debounces the buttons, then runs a HOLD/MANUAL/AUTO state machine. It also exposes mode, state and a tick counter so the mapping can drive the status LEDs.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles before a synchronised button level is accepted (must be >=1)
AUTO_DIV, 25000000, clk cycles per cpu_clk_en pulse in AUTO mode (must be >=2)
RESET_HOLD, 4, cycles cpu_reset stays high after the reset button is released (must be >=1)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
auto_en_raw  input  1  raw auto-run switch level
step_raw  input  1  raw single-step button level
reset_req_raw  input  1  raw CPU-reset button level, active-high
cpu_clk_en  output  1  one-cycle clock-enable pulse to the CPU datapath and controller
cpu_reset  output  1  synchronous active-high reset to the CPU
run_mode  output  1  1 while in AUTO
ctrl_state  output  2  FSM state: HOLD=0, MANUAL=1, AUTO=2 (3 never driven)
tick_count  output  8  number of cpu_clk_en pulses since the last HOLD exit, wrapping

Behaviour:
- The clock is clk; reset is asynchronous and active-low (reset_n).
- When reset_n=0: all sync flops, debounced levels and counters go to 0, and state=HOLD. Outputs are cpu_reset=1, cpu_clk_en=0, run_mode=0, ctrl_state=0, tick_count=0.
- Synchronisers: each raw input passes through its own 2-flop synchroniser.
- Debounce, per input:
  - A counter increments while the synchronised value differs from the debounced value.
  - It clears whenever the two are equal.
  - When it reaches DEBOUNCE_CYCLES, the debounced value takes the synchronised value and the counter clears.
- step_rise: registered rising edge of debounced step; it is high for exactly 1 cycle.
- Latency: with a clean raw step rise first sampled in cycle 0, a MANUAL-mode cpu_clk_en is high in cycle DEBOUNCE_CYCLES+3 only.
- HOLD state:
  - Outputs: cpu_reset=1, cpu_clk_en=0, tick_count cleared.
  - The hold counter stays at 0 while debounced reset_req=1, and increments while it is 0.
  - When the hold counter reaches RESET_HOLD, the FSM moves to AUTO if debounced auto_en=1, otherwise to MANUAL. cpu_reset falls in the first cycle of the new state.
- MANUAL state:
  - cpu_clk_en = step_rise.
  - Debounced auto_en=1 moves the FSM to AUTO and clears the divider.
- AUTO state:
  - The divider counts 0..AUTO_DIV-1. cpu_clk_en=1 in the cycle the divider equals AUTO_DIV-1, after which it wraps to 0.
  - step_rise is ignored.
  - Debounced auto_en=0 moves the FSM to MANUAL; the divider clears and no pulse is issued in that cycle.
- Priority in any state: debounced reset_req=1 moves the FSM to HOLD and clears the hold counter. This outranks a mode change, which outranks a tick.
  - A reset_req arriving in the same cycle as a pending tick suppresses the tick.
  - A reset_req arriving mid-count in AUTO discards the partial divider count.
- tick_count increments in the cycle after each cpu_clk_en pulse and wraps 255->0.
- Invariants:
  - cpu_clk_en is never high for two consecutive cycles.
  - cpu_clk_en is never high while cpu_reset=1.
- run_mode = (state==AUTO). ctrl_state, run_mode and cpu_reset are registered outputs.
- Mode switch: AUTO->MANUAL->AUTO restarts the divider from 0; the next pulse comes AUTO_DIV cycles after re-entry.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, AUTO_DIV=8, RESET_HOLD=3.
1. Reset release: deassert reset_n with all raw inputs 0 -> cpu_reset=1 for 3 cycles after the debounced state settles, then ctrl_state=1, cpu_reset=0, tick_count=0.
2. Clean step in MANUAL: raise step_raw in cycle 0 and hold it -> cpu_clk_en high in cycle 7 only, tick_count=1 in cycle 8. Releasing and re-pressing yields tick_count=2.
3. Bounce rejection: toggle step_raw high for 3 cycles, low for 1, repeated 5 times, then low -> no cpu_clk_en, tick_count stays 0.
4. AUTO run: hold auto_en_raw=1 -> ctrl_state=2, run_mode=1, cpu_clk_en every 8th cycle, tick_count advances 0,1,2..., 255 wraps to 0. Step presses during AUTO cause no extra pulses.
5. Reset mid-AUTO: assert reset_req_raw with the divider at 5 -> no further pulse, ctrl_state=0, cpu_reset=1, tick_count=0. After release it returns to AUTO and the first pulse arrives 8 cycles after entry.
6. Async reset mid-operation: drop reset_n while in AUTO, between pulses -> all outputs immediately at reset values without waiting for a clk edge.
